// File: rtl/boot_loader.sv
// Boot-copy engine: copies the ROM data image into RAM under core reset, then passes core traffic through.
// Optional readback verify of the copied image is compiled in with `define BOOT_VERIFY_EN.
module boot_loader #(
    parameter int AWIDTH     = 14,
    parameter int XLEN       = 32,
    parameter int SRC_BASE   = 'h800,
    parameter int COPY_BYTES = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              core_rst_n,
    output logic              done,
    output logic              boot_err,
    input  logic [AWIDTH-1:0] core_inst_addr,
    output logic [XLEN-1:0]   core_inst_data,
    input  logic [AWIDTH-1:0] core_dmem_addr,
    input  logic [XLEN-1:0]   core_dmem_wdata,
    input  logic [2:0]        core_dmem_we,
    output logic [XLEN-1:0]   core_dmem_rdata,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_qout,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [XLEN-1:0]   ram_qin,
    output logic [2:0]        ram_we,
    input  logic [XLEN-1:0]   ram_qout
);

    localparam int                IDX_W    = AWIDTH - 2;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COPY_BYTES / 4 - 1);
    localparam logic [AWIDTH-1:0] SRC_ADDR = AWIDTH'(SRC_BASE);
    localparam logic [2:0]        WE_WORD  = 3'b110;

    localparam logic [2:0] ST_COPY   = 3'd0;
    localparam logic [2:0] ST_FLUSH  = 3'd1;
`ifdef BOOT_VERIFY_EN
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_VFLUSH = 3'd3;
`endif
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             wr_vld_q, wr_vld_d;
    logic             done_q, done_d;
`ifdef BOOT_VERIFY_EN
    logic             boot_err_q, boot_err_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_COPY;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            wr_vld_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef BOOT_VERIFY_EN
            boot_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            wr_vld_q   <= wr_vld_d;
            done_q     <= done_d;
`ifdef BOOT_VERIFY_EN
            boot_err_q <= boot_err_d;
`endif
        end
    end

    // wr_vld/wr_idx trail rd_idx by one cycle; in verify they mark the pending compare.
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = rd_idx_q;
        wr_vld_d = 1'b0;
        done_d   = done_q;
`ifdef BOOT_VERIFY_EN
        boot_err_d = boot_err_q;
`endif
        case (state_q)
            ST_COPY: begin
                wr_vld_d = 1'b1;
                rd_idx_d = rd_idx_q + 1'b1;
                if (rd_idx_q == LAST_IDX) begin
                    state_d  = ST_FLUSH;
                    rd_idx_d = '0;
                end
            end
            ST_FLUSH: begin
`ifdef BOOT_VERIFY_EN
                state_d = ST_VERIFY;
`else
                state_d = ST_DONE;
                done_d  = 1'b1;
`endif
            end
`ifdef BOOT_VERIFY_EN
            ST_VERIFY: begin
                wr_vld_d = 1'b1;
                rd_idx_d = rd_idx_q + 1'b1;
                if (wr_vld_q && (rom_qout != ram_qout)) begin
                    boot_err_d = 1'b1;
                end
                if (rd_idx_q == LAST_IDX) begin
                    state_d  = ST_VFLUSH;
                    rd_idx_d = '0;
                end
            end
            ST_VFLUSH: begin
                if (wr_vld_q && (rom_qout != ram_qout)) begin
                    boot_err_d = 1'b1;
                end
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        rom_addr = SRC_ADDR + {rd_idx_q, 2'b00};
        ram_addr = {wr_idx_q, 2'b00};
        ram_qin  = rom_qout;
        ram_we   = '0;
        case (state_q)
            ST_COPY, ST_FLUSH: begin
                if (wr_vld_q) begin
                    ram_we = WE_WORD;
                end
            end
`ifdef BOOT_VERIFY_EN
            ST_VERIFY: begin
                ram_addr = {rd_idx_q, 2'b00};
            end
`endif
            ST_DONE: begin
                rom_addr = core_inst_addr;
                ram_addr = core_dmem_addr;
                ram_qin  = core_dmem_wdata;
                ram_we   = core_dmem_we;
            end
            default: ;
        endcase
        // Registers only clear at the edge, so the reset cycle itself is gated here.
        if (!rst_n) begin
            rom_addr = SRC_ADDR;
            ram_we   = '0;
        end
    end

    assign done            = done_q;
    assign core_rst_n      = rst_n & done_q;
    assign core_inst_data  = rom_qout;
    assign core_dmem_rdata = ram_qout;
`ifdef BOOT_VERIFY_EN
    assign boot_err = boot_err_q;
`else
    assign boot_err = 1'b0;
`endif

endmodule
